// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter controller: register offsets,
// CTRL command bits and the run-state encoding.
package perf_pkg;

    localparam logic [5:0] PERF_CTRL       = 6'h00;
    localparam logic [5:0] PERF_CYCLE_LO   = 6'h04;
    localparam logic [5:0] PERF_CYCLE_HI   = 6'h08;
    localparam logic [5:0] PERF_INSTRET_LO = 6'h0C;
    localparam logic [5:0] PERF_INSTRET_HI = 6'h10;
    localparam logic [5:0] PERF_BRPRED_LO  = 6'h14;
    localparam logic [5:0] PERF_BRPRED_HI  = 6'h18;
    localparam logic [5:0] PERF_BRMISP_LO  = 6'h1C;
    localparam logic [5:0] PERF_BRMISP_HI  = 6'h20;
    localparam logic [5:0] PERF_WIN_END    = 6'h24;

    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;
    localparam int CTRL_CLEAR = 2;

    localparam int NUM_CNTR = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } perf_state_e;

endpackage

// File: rtl/perf_cntr64.sv
// One 64-bit event counter; a clear in the same cycle as an increment wins.
module perf_cntr64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [63:0] cnt_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/perf_cntr_ctrl.sv
// MMIO performance counter block: run/stop/clear sequencing, four 64-bit
// counters and coherent lo/hi reads through a shared high-word shadow.
module perf_cntr_ctrl
    import perf_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0100,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        retire_v_i,
    input  logic        ctrl_tsfr_i,
    input  logic        br_misp_i,
    input  logic [31:0] dbus_addr_i,
    input  logic        dbus_wvalid_i,
    input  logic [31:0] dbus_wdata_i,
    input  logic        dbus_rvalid_i,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic        running_o
);

    perf_state_e state_q;
    perf_state_e state_d;

    logic              sel;
    logic [3:0]        widx;
    logic              ctrl_wr;
    logic              cmd_start;
    logic              cmd_stop;
    logic              cmd_clear;
    logic              rd_req;
    logic              cnt_en;
    logic [NUM_CNTR-1:0] cnt_ev;
    logic [63:0]       cnt [NUM_CNTR];

    logic [31:0]       rdata_q;
    logic [31:0]       rdata_d;
    logic              rvalid_q;
    logic [31:0]       shadow_q;
    logic [31:0]       shadow_d;

    logic              unused_bits;
    assign unused_bits = ^{dbus_wdata_i[31:3], dbus_addr_i[1:0]};

    assign sel       = (dbus_addr_i[31:6] == BASE_ADDR[31:6]) && (dbus_addr_i[5:0] < PERF_WIN_END);
    assign widx      = dbus_addr_i[5:2];
    assign ctrl_wr   = sel && dbus_wvalid_i && (widx == PERF_CTRL[5:2]);
    assign cmd_start = ctrl_wr && dbus_wdata_i[CTRL_START];
    assign cmd_stop  = ctrl_wr && dbus_wdata_i[CTRL_STOP];
    assign cmd_clear = ctrl_wr && dbus_wdata_i[CTRL_CLEAR];
    assign rd_req    = sel && dbus_rvalid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= AUTO_START ? RUN : IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // STOP dominates START when both are set in one write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_start && !cmd_stop) state_d = RUN;
            RUN:     if (cmd_stop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        running_o = (state_q == RUN);
        cnt_en    = (state_q == RUN);
    end

    assign cnt_ev[0] = 1'b1;
    assign cnt_ev[1] = retire_v_i && !stall_i;
    assign cnt_ev[2] = ctrl_tsfr_i;
    assign cnt_ev[3] = ctrl_tsfr_i && br_misp_i;

    perf_cntr64 u_cycle (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cmd_clear),
        .inc_i (cnt_en && cnt_ev[0]),
        .cnt_o (cnt[0])
    );

    perf_cntr64 u_instret (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cmd_clear),
        .inc_i (cnt_en && cnt_ev[1]),
        .cnt_o (cnt[1])
    );

    perf_cntr64 u_brpred (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cmd_clear),
        .inc_i (cnt_en && cnt_ev[2]),
        .cnt_o (cnt[2])
    );

    perf_cntr64 u_brmisp (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cmd_clear),
        .inc_i (cnt_en && cnt_ev[3]),
        .cnt_o (cnt[3])
    );

    // Lo words sit at odd word indices, so widx[2:1] names the counter.
    // Any even nonzero index is a hi word and returns the shared shadow.
    always_comb begin
        rdata_d  = '0;
        shadow_d = shadow_q;
        if (rd_req) begin
            if (widx == PERF_CTRL[5:2]) begin
                rdata_d = {31'd0, running_o};
            end else if (widx[0]) begin
                rdata_d  = cnt[widx[2:1]][31:0];
                shadow_d = cnt[widx[2:1]][63:32];
            end else begin
                rdata_d = shadow_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            shadow_q <= '0;
        end else begin
            rvalid_q <= rd_req;
            rdata_q  <= rdata_d;
            shadow_q <= shadow_d;
        end
    end

    // A reset arriving while a response is in flight drops it.
    assign rvalid_o = rvalid_q && !rst_i;
    assign rdata_o  = rst_i ? 32'd0 : rdata_q;

endmodule

// File: tb/tb_perf_cntr_ctrl.sv
// Directed self-checking bench for perf_cntr_ctrl with hand-computed counts.
module tb_perf_cntr_ctrl;
    import perf_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0100;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        retire_v_i = 1'b0;
    logic        ctrl_tsfr_i = 1'b0;
    logic        br_misp_i = 1'b0;
    logic [31:0] dbus_addr_i = '0;
    logic        dbus_wvalid_i = 1'b0;
    logic [31:0] dbus_wdata_i = '0;
    logic        dbus_rvalid_i = 1'b0;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        running_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    perf_cntr_ctrl #(
        .BASE_ADDR  (BASE),
        .AUTO_START (1'b0)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .retire_v_i    (retire_v_i),
        .ctrl_tsfr_i   (ctrl_tsfr_i),
        .br_misp_i     (br_misp_i),
        .dbus_addr_i   (dbus_addr_i),
        .dbus_wvalid_i (dbus_wvalid_i),
        .dbus_wdata_i  (dbus_wdata_i),
        .dbus_rvalid_i (dbus_rvalid_i),
        .rdata_o       (rdata_o),
        .rvalid_o      (rvalid_o),
        .running_o     (running_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [5:0] off, input logic [31:0] data);
        dbus_addr_i   = BASE + 32'(off);
        dbus_wdata_i  = data;
        dbus_wvalid_i = 1'b1;
        step();
        dbus_wvalid_i = 1'b0;
        dbus_wdata_i  = '0;
    endtask

    task automatic bus_read(input string tag, input logic [5:0] off, input logic [31:0] exp);
        dbus_addr_i   = BASE + 32'(off);
        dbus_rvalid_i = 1'b1;
        step();
        dbus_rvalid_i = 1'b0;
        check({tag, "_vld"}, 64'(rvalid_o), 64'd1);
        check(tag, 64'(rdata_o), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset, AUTO_START=0
        step();
        check("rst_rvalid", 64'(rvalid_o), 64'd0);
        check("rst_rdata", 64'(rdata_o), 64'd0);
        check("rst_running", 64'(running_o), 64'd0);
        step();
        rst_i = 1'b0;

        // Idle: nothing counts
        repeat (10) step();
        bus_read("idle_cyc_lo", PERF_CYCLE_LO, 32'd0);
        step();
        check("rvalid_pulse", 64'(rvalid_o), 64'd0);
        check("rdata_idle0", 64'(rdata_o), 64'd0);
        bus_read("status_idle", PERF_CTRL, 32'd0);

        // CLEAR+START, 100 cycles, STOP: 100 + the STOP write edge = 101
        bus_write(PERF_CTRL, 32'h5);
        check("run_after_start", 64'(running_o), 64'd1);
        repeat (100) step();
        bus_write(PERF_CTRL, 32'h2);
        check("idle_after_stop", 64'(running_o), 64'd0);
        bus_read("cyc100_lo", PERF_CYCLE_LO, 32'd101);
        bus_read("cyc100_hi", PERF_CYCLE_HI, 32'd0);

        // Carry across the 32-bit boundary and shadow coherence
        force dut.u_cycle.cnt_q = 64'h0000_0000_FFFF_FFFE;
        step();
        release dut.u_cycle.cnt_q;
        bus_write(PERF_CTRL, 32'h1);
        step();
        step();
        bus_write(PERF_CTRL, 32'h2);
        dbus_rvalid_i = 1'b1;
        dbus_addr_i   = BASE + 32'(PERF_CYCLE_HI);
        step();
        check("stale_hi_vld", 64'(rvalid_o), 64'd1);
        check("stale_hi", 64'(rdata_o), 64'd0);
        dbus_addr_i = BASE + 32'(PERF_CYCLE_LO);
        step();
        check("carry_lo_vld", 64'(rvalid_o), 64'd1);
        check("carry_lo", 64'(rdata_o), 64'd1);
        dbus_addr_i = BASE + 32'(PERF_CYCLE_HI);
        step();
        check("carry_hi_vld", 64'(rvalid_o), 64'd1);
        check("carry_hi", 64'(rdata_o), 64'd1);
        dbus_rvalid_i = 1'b0;
        step();
        check("b2b_end_vld", 64'(rvalid_o), 64'd0);
        check("b2b_end_data", 64'(rdata_o), 64'd0);

        // Event counters
        bus_write(PERF_CTRL, 32'h5);
        for (int i = 0; i < 20; i++) begin
            retire_v_i = 1'b1;
            stall_i    = (i % 4 == 0);
            step();
        end
        retire_v_i = 1'b0;
        stall_i    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ctrl_tsfr_i = 1'b1;
            br_misp_i   = (i < 3);
            step();
        end
        ctrl_tsfr_i = 1'b0;
        br_misp_i   = 1'b1;
        step();
        br_misp_i = 1'b0;
        bus_write(PERF_CTRL, 32'h2);
        bus_read("instret_lo", PERF_INSTRET_LO, 32'd15);
        bus_read("instret_hi", PERF_INSTRET_HI, 32'd0);
        bus_read("brpred_lo", PERF_BRPRED_LO, 32'd8);
        bus_read("brmisp_lo", PERF_BRMISP_LO, 32'd3);
        bus_read("brmisp_hi", PERF_BRMISP_HI, 32'd0);
        bus_read("cyc_ev_lo", PERF_CYCLE_LO, 32'd30);
        retire_v_i = 1'b1;
        repeat (3) step();
        retire_v_i = 1'b0;
        bus_read("instret_idle", PERF_INSTRET_LO, 32'd15);
        bus_read("misaligned", 6'h0D, 32'd15);
        bus_write(PERF_INSTRET_LO, 32'h1234);
        bus_read("cnt_wr_ignored", PERF_INSTRET_LO, 32'd15);

        // Unselected accesses
        dbus_addr_i   = BASE + 32'h24;
        dbus_rvalid_i = 1'b1;
        step();
        dbus_rvalid_i = 1'b0;
        check("unsel_win_end", 64'(rvalid_o), 64'd0);
        dbus_addr_i   = 32'h8000_0200;
        dbus_rvalid_i = 1'b1;
        dbus_wvalid_i = 1'b1;
        dbus_wdata_i  = 32'h1;
        step();
        dbus_rvalid_i = 1'b0;
        dbus_wvalid_i = 1'b0;
        dbus_wdata_i  = '0;
        check("unsel_base_rd", 64'(rvalid_o), 64'd0);
        check("unsel_base_wr", 64'(running_o), 64'd0);

        // Command combinations
        bus_write(PERF_CTRL, 32'h3);
        check("stopstart_idle", 64'(running_o), 64'd0);
        bus_write(PERF_CTRL, 32'h1);
        check("start_again", 64'(running_o), 64'd1);
        bus_write(PERF_CTRL, 32'h3);
        check("stopstart_run", 64'(running_o), 64'd0);
        bus_write(PERF_CTRL, 32'h1);
        retire_v_i = 1'b1;
        bus_write(PERF_CTRL, 32'h4);
        retire_v_i = 1'b0;
        check("clear_keeps_run", 64'(running_o), 64'd1);

        // Read STATUS and write STOP in the same cycle
        dbus_addr_i   = BASE + 32'(PERF_CTRL);
        dbus_rvalid_i = 1'b1;
        dbus_wvalid_i = 1'b1;
        dbus_wdata_i  = 32'h2;
        step();
        dbus_rvalid_i = 1'b0;
        dbus_wvalid_i = 1'b0;
        dbus_wdata_i  = '0;
        check("collide_vld", 64'(rvalid_o), 64'd1);
        check("collide_status", 64'(rdata_o), 64'd1);
        check("collide_stop", 64'(running_o), 64'd0);
        bus_read("clear_vs_retire", PERF_INSTRET_LO, 32'd0);
        bus_read("clear_brpred", PERF_BRPRED_LO, 32'd0);
        bus_read("cyc_after_clr", PERF_CYCLE_LO, 32'd1);

        // Reset while a read response is in flight
        bus_write(PERF_CTRL, 32'h1);
        retire_v_i = 1'b1;
        repeat (4) step();
        retire_v_i = 1'b0;
        bus_write(PERF_CTRL, 32'h2);
        bus_read("pre_rst_cyc", PERF_CYCLE_LO, 32'd6);
        dbus_addr_i   = BASE + 32'(PERF_INSTRET_LO);
        dbus_rvalid_i = 1'b1;
        step();
        dbus_rvalid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check("rst_drop_vld", 64'(rvalid_o), 64'd0);
        check("rst_drop_data", 64'(rdata_o), 64'd0);
        step();
        rst_i = 1'b0;
        check("post_rst_running", 64'(running_o), 64'd0);
        check("post_rst_vld", 64'(rvalid_o), 64'd0);
        bus_read("post_rst_hi", PERF_CYCLE_HI, 32'd0);
        bus_read("post_rst_cyc", PERF_CYCLE_LO, 32'd0);
        bus_read("post_rst_inst", PERF_INSTRET_LO, 32'd0);
        bus_read("post_rst_brp", PERF_BRPRED_LO, 32'd0);
        bus_read("post_rst_brm", PERF_BRMISP_LO, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
